ucode_sequencer: RTL
====================

Name: ucode_sequencer

Overview:
- Microprogram sequencer for the matrix-multiplication core's microcode ROM.
- Owns the micro-program counter (uPC) and drives it onto the ROM address input.
- Uses the ROM outputs (branch-type bit, 2-bit condition, 7-bit jump address) together with status and handshake inputs to choose the next uPC every clock.
- Also handles start/halt, opcode dispatch, memory wait states and illegal-address faults, and counts executed micro-instructions.

Parameters:
- ADDR_W, 16, uPC width; matches the ROM address port.
- JUMP_W, 7, width of the ROM jump field.
- OPC_W, 8, instruction-register opcode width.
- UCODE_DEPTH, 86, number of valid ROM words (addresses 0..85).
- FETCH_ADDR, 1, first micro-instruction of the fetch routine.
- CNT_W, 16, micro-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE or HALT.
- stall  in  1  freeze the sequencer this cycle.
- z_flag  in  1  datapath zero flag.
- mem_ready  in  1  memory/core handshake completion.
- ir_opcode  in  OPC_W  current instruction opcode, used for dispatch.
- bt  in  1  ROM branch-type bit (1 = opcode dispatch).
- condition  in  2  ROM condition field.
- jump_addr  in  JUMP_W  ROM next-address field.
- upc  out  ADDR_W  ROM address.
- busy  out  1  high in RUN or WAIT.
- done  out  1  high in HALT after a normal halt.
- illegal_op  out  1  sticky fault flag.
- uinst_count  out  CNT_W  executed micro-instruction count.

Behaviour:
- Reset (async, any state): state = IDLE; upc = 0; busy = 0; done = 0; illegal_op = 0; uinst_count = 0. ROM word 0 is all-zero, so the datapath sees no operations.
- States: IDLE, RUN, WAIT, HALT.
- IDLE/HALT with start = 1: upc <= FETCH_ADDR; state <= RUN; done, illegal_op and uinst_count cleared. start is ignored in RUN and WAIT.
- The ROM is combinational. The fields present on the ROM outputs in a cycle belong to the current upc; the next upc registers at the clock edge (1-cycle latency per micro-instruction).
- Priority in RUN: stall > fault check > bt dispatch > condition decode.
- stall = 1 (RUN or WAIT): upc, state and counter hold.
- bt = 1: target = zero-extended ir_opcode; the condition field is ignored.
- bt = 0, condition 00: target = jump_addr, unconditional.
- bt = 0, condition 01: target = z_flag ? jump_addr : upc + 1.
- bt = 0, condition 10: target = z_flag ? upc + 1 : jump_addr.
- bt = 0, condition 11 (wait):
  - mem_ready = 1: target = jump_addr.
  - mem_ready = 0: state <= WAIT; upc holds.
- WAIT: upc holds until mem_ready = 1, then upc <= jump_addr and state <= RUN. A stall in the same cycle takes priority.
- Halt: bt = 0, condition 00 and jump_addr == upc[JUMP_W-1:0] (self-loop) → state <= HALT; upc <= 0; done <= 1.
- Fault: a target >= UCODE_DEPTH (covers opcode, jump and upc + 1 overflow) → state <= HALT; upc <= 0; illegal_op <= 1; done stays 0.
- uinst_count increments by 1 on every RUN cycle that loads a new upc, including the cycle that enters HALT. It does not increment on stall or WAIT hold cycles and saturates at 2^CNT_W − 1.
- busy is registered and equals (state == RUN || state == WAIT).

Decomposition:
- Shared package ucode_pkg:
  - Condition encodings COND_ALWAYS = 2'b00, COND_Z = 2'b01, COND_NZ = 2'b10, COND_WAIT = 2'b11.
  - UCODE_DEPTH, FETCH_ADDR.
  - Sequencer state enum.
- One sub-module, useq_next_addr: combinational next-address and fault/halt decode.
- The FSM and counter stay in ucode_sequencer.

Test Plan:
- Reset, then start pulse with ir_opcode = 5 → upc sequence 1, 2, 3 (bt = 1, dispatch), 5, 6, 7, 1. uinst_count = 6 when upc returns to 1.
- upc = 60 (condition 01, jump 62): z_flag = 1 → next upc 62. z_flag = 0 → next upc 61.
- Condition-11 word with jump_addr 10, mem_ready low for 3 cycles → state WAIT, upc holds 3 cycles, count unchanged. mem_ready high → upc = 10.
- upc = 80 (self-jump) → HALT, done = 1, upc = 0, busy = 0. A new start → upc = 1, done cleared.
- Dispatch with ir_opcode = 100 → illegal_op = 1, upc = 0, done = 0. stall held 4 cycles mid-RUN → upc and count frozen.
- Assert rst mid-WAIT, asynchronously between clock edges → upc = 0 and state IDLE immediately. start is ignored until rst is deasserted.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared definitions for the microcode sequencer: condition encodings,
// ROM geometry and the sequencer state type.
package ucode_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned JUMP_W      = 7;
  localparam int unsigned OPC_W       = 8;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned UCODE_DEPTH = 86;
  localparam int unsigned FETCH_ADDR  = 1;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_WAIT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/useq_next_addr.sv
// Combinational next-address selection plus halt, fault and wait decode
// for the microcode sequencer.
module useq_next_addr
  import ucode_pkg::*;
(
  input  logic [ADDR_W-1:0] upc,
  input  logic              in_wait,
  input  logic              bt,
  input  logic [1:0]        condition,
  input  logic [JUMP_W-1:0] jump_addr,
  input  logic [OPC_W-1:0]  ir_opcode,
  input  logic              z_flag,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] target_c,
  output logic              hold_c,
  output logic              halt_c,
  output logic              fault_c
);

  localparam int unsigned TW = ADDR_W + 1;

  logic [TW-1:0] jump_ext;
  logic [TW-1:0] upc_inc;
  logic [TW-1:0] tgt;
  logic          self_loop;

  assign jump_ext = TW'(jump_addr);
  assign upc_inc  = TW'(upc) + TW'(1);

  // One extra bit on the target so upc + 1 overflow is still seen as a fault.
  always_comb begin
    tgt       = jump_ext;
    hold_c    = 1'b0;
    self_loop = 1'b0;
    if (in_wait) begin
      hold_c = !mem_ready;
    end else if (bt) begin
      tgt = TW'(ir_opcode);
    end else begin
      case (condition)
        COND_ALWAYS: self_loop = (jump_addr == upc[JUMP_W-1:0]);
        COND_Z:      tgt = z_flag ? jump_ext : upc_inc;
        COND_NZ:     tgt = z_flag ? upc_inc : jump_ext;
        default:     hold_c = !mem_ready;
      endcase
    end
  end

  assign fault_c  = !hold_c && (tgt >= TW'(UCODE_DEPTH));
  assign halt_c   = self_loop && !fault_c;
  assign target_c = tgt[ADDR_W-1:0];

endmodule

// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: owns the uPC, runs the IDLE/RUN/WAIT/HALT FSM and
// counts executed micro-instructions.
module ucode_sequencer
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              z_flag,
  input  logic              mem_ready,
  input  logic [OPC_W-1:0]  ir_opcode,
  input  logic              bt,
  input  logic [1:0]        condition,
  input  logic [JUMP_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] upc,
  output logic              busy,
  output logic              done,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  uinst_count
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] target_c;
  logic              hold_c, halt_c, fault_c;
  logic              start_acc, adv, halt_acc, fault_acc;

  useq_next_addr u_next_addr (
    .upc       (upc_q),
    .in_wait   (state_q == ST_WAIT),
    .bt        (bt),
    .condition (condition),
    .jump_addr (jump_addr),
    .ir_opcode (ir_opcode),
    .z_flag    (z_flag),
    .mem_ready (mem_ready),
    .target_c  (target_c),
    .hold_c    (hold_c),
    .halt_c    (halt_c),
    .fault_c   (fault_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      upc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state and uPC; stall outranks everything while RUN or WAIT.
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    start_acc = 1'b0;
    adv       = 1'b0;
    halt_acc  = 1'b0;
    fault_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_RUN;
          upc_d     = ADDR_W'(FETCH_ADDR);
          start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (fault_c || halt_c) begin
            state_d   = ST_HALT;
            upc_d     = '0;
            adv       = 1'b1;
            fault_acc = fault_c;
            halt_acc  = halt_c;
          end else if (hold_c) begin
            state_d = ST_WAIT;
          end else begin
            upc_d = target_c;
            adv   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!stall && !hold_c) begin
          if (fault_c) begin
            state_d   = ST_HALT;
            upc_d     = '0;
            fault_acc = 1'b1;
          end else begin
            state_d = ST_RUN;
            upc_d   = target_c;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        upc_d   = '0;
      end
    endcase
  end

  // Registered status outputs and the saturating instruction counter.
  always_comb begin
    busy_d    = (state_d == ST_RUN) || (state_d == ST_WAIT);
    done_d    = done_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (start_acc) begin
      done_d    = 1'b0;
      illegal_d = 1'b0;
      cnt_d     = '0;
    end else begin
      if (halt_acc)  done_d    = 1'b1;
      if (fault_acc) illegal_d = 1'b1;
      if (adv && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign upc         = upc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal_op  = illegal_q;
  assign uinst_count = cnt_q;

endmodule
